ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Consumer side of the PC register. Reads the current PC and issues a word read on the instruction-memory request/acknowledge handshake.
- Buffers the returned instruction and presents it to decode with a valid/ready handshake.
- Pulses the PC register's enable when a fetch completes.
- Handles redirects (branch/jump) and fetch errors (misalignment, memory timeout).

Parameters:
- MAX_WAIT, 255: cycles mem_req may stay unacknowledged in FETCH before timeout; legal range 1..65535.
- CNT_W, 16: wait-counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  32  current PC from the PC register output.
- pc_en  out  1  enable to the PC register, combinational. PC register loads its next value (pc+4 or target) on the same edge.
- redirect  in  1  branch/jump taken this cycle; flush and refetch.
- mem_req  out  1  instruction read request.
- mem_addr  out  32  read address, registered.
- mem_ack  in  1  memory accepted the request; mem_rdata is valid this cycle.
- mem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc valid to decode.
- inst  out  32  fetched instruction.
- inst_pc  out  32  address of inst.
- inst_ready  in  1  decode accepts inst this cycle.
- fetch_err  out  1  sticky fetch error flag; cleared only by redirect or reset.

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, wait counter=0. pc_en=0 throughout reset.
- States: IDLE, FETCH, HOLD, DISCARD, ERR.
- IDLE, redirect=0:
  - pc[1:0]!=0: fetch_err<=1, go ERR, no request issued.
  - Otherwise: mem_addr<=pc, mem_req<=1, counter<=0, go FETCH.
- FETCH:
  - mem_req held high and mem_addr held stable until mem_ack=1.
  - On mem_ack & !redirect: pc_en=1 that cycle. At the edge: inst<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1, mem_req<=0, go HOLD.
  - Otherwise counter increments. When counter==MAX_WAIT-1 with no ack: mem_req<=0, fetch_err<=1, go ERR. This is the only abort of a pending request.
- HOLD:
  - inst_valid=1; inst and inst_pc held stable while inst_ready=0.
  - On inst_ready: inst_valid<=0. If the current pc is aligned, issue the next request directly (mem_addr<=pc, mem_req<=1, go FETCH). Otherwise set fetch_err and go ERR.
  - Throughput: one instruction per 2 cycles at zero-wait memory with inst_ready tied high.
- DISCARD: mem_req held with the old mem_addr until mem_ack. The returned data is dropped, pc_en stays 0, mem_req<=0, go IDLE. No timeout applies. A redirect here keeps the state in DISCARD.
- ERR: mem_req=0, inst_valid=0. Stays in ERR until redirect.
- Redirect has highest priority. pc_en=0 in any cycle where redirect=1. The PC register loads the target through its own path.
  - IDLE/HOLD/ERR: inst_valid<=0, fetch_err<=0, go IDLE. Refetch at the new pc on the next cycle.
  - FETCH without ack: go DISCARD; mem_req stays high.
  - FETCH with ack in the same cycle: data dropped, mem_req<=0, go IDLE.
- Handshake rules:
  - mem_ack is ignored while mem_req=0.
  - inst_ready is ignored while inst_valid=0.
  - mem_req never falls before ack except on timeout.
- Reset mid-transfer: all outputs return to their reset values immediately. Memory must tolerate a dropped request.

Test Plan:
- Zero-wait fetch: pc=0x00400000, mem_ack same cycle as mem_req, mem_rdata=0x3C1D1000, inst_ready=1 -> inst_valid rises 1 cycle after ack with inst=0x3C1D1000 and inst_pc=0x00400000; pc_en is high for exactly the ack cycle.
- Decode backpressure: inst_ready=0 for 5 cycles -> inst/inst_pc stable and no new mem_req. inst_ready=1 -> next mem_req issued with mem_addr=0x00400004 on the following cycle.
- Redirect while waiting: mem_ack delayed 3 cycles, redirect pulses in wait cycle 1 -> mem_req stays high with the old address until ack, data dropped, inst_valid stays 0, pc_en stays 0. The next request uses the new pc.
- Redirect coincident with ack -> no inst_valid, pc_en=0, IDLE then FETCH at the target.
- Timeout: MAX_WAIT=4, mem_ack never asserted -> mem_req drops after 4 cycles, fetch_err=1, no further requests. Redirect clears fetch_err and fetching resumes.
- Misaligned pc=0x00400002 -> fetch_err=1 with no mem_req. Async rst low mid-FETCH -> mem_req=0 and inst_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: PC register link, instruction-memory handshake and decode handshake.
// master = fetch unit side, slave = PC register / memory / decode side.
interface ifetch_unit_if;
    logic        pc_en;
    logic [31:0] pc;
    logic        redirect;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_err;

    modport master (
        input  pc, redirect, mem_ack, mem_rdata, inst_ready,
        output pc_en, mem_req, mem_addr, inst_valid, inst, inst_pc, fetch_err
    );

    modport slave (
        output pc, redirect, mem_ack, mem_rdata, inst_ready,
        input  pc_en, mem_req, mem_addr, inst_valid, inst, inst_pc, fetch_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: reads PC, issues word reads to instruction memory,
// buffers one instruction for decode, and handles redirects and fetch errors.
module ifetch_unit #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             inst_valid;
    logic [31:0]      inst;
    logic [31:0]      inst_pc;
    logic             fetch_err;
    logic [CNT_W-1:0] wait_cnt;

    logic pc_aligned;
    logic fetch_done;

    assign pc_aligned = (bus.pc[1:0] == 2'b00);
    // A fetch only completes when no redirect competes with the ack.
    assign fetch_done = (state == FETCH) && bus.mem_ack && !bus.redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            fetch_err  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        inst_valid <= 1'b0;
                        fetch_err  <= 1'b0;
                    end else if (!pc_aligned) begin
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        mem_addr <= bus.pc;
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        if (bus.redirect) begin
                            state <= IDLE;
                        end else begin
                            inst       <= bus.mem_rdata;
                            inst_pc    <= mem_addr;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (bus.redirect) begin
                        state <= DISCARD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (bus.redirect) begin
                        inst_valid <= 1'b0;
                        fetch_err  <= 1'b0;
                        state      <= IDLE;
                    end else if (bus.inst_ready) begin
                        inst_valid <= 1'b0;
                        // PC already advanced on the ack edge, so pc is the next word.
                        if (pc_aligned) begin
                            mem_addr <= bus.pc;
                            mem_req  <= 1'b1;
                            wait_cnt <= '0;
                            state    <= FETCH;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end
                    end
                end

                DISCARD: begin
                    if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end

                ERR: begin
                    if (bus.redirect) begin
                        inst_valid <= 1'b0;
                        fetch_err  <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    mem_req    <= 1'b0;
                    inst_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc_en      = fetch_done;
    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = mem_addr;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst;
    assign bus.inst_pc    = inst_pc;
    assign bus.fetch_err  = fetch_err;

endmodule
